bira_seq_ctrl: RTL and testbench
================================

// Module: bira_seq_ctrl
// PURPOSE
//  Session sequencer between BIST and the BIRA analyzer core. Buffers fault reports in a FIFO, paces
//  BIST with a pause signal and feeds the analyzer under a valid/ready handshake. Counts pivot faults
//  for early termination, starts analysis at test end, then forwards the repair solution words.
// PARAMETERS
//  FIFO_DEPTH  8   fault FIFO entries (power of 2, >=4)
//  CNT_W       4   pivot/solution counter width
// PORTS
//  clk          in   1   system clock (100 MHz)
//  rst          in   1   asynchronous reset, active-high
//  start        in   1   1-cycle pulse: begin repair session
//  spare_struct in   2   spare structure type, latched at start
//  fault_detect in   1   BIST fault strobe
//  row_add_in   in   10  fault row address
//  col_add_in   in   10  fault column address
//  col_flag     in   8   fault column flag
//  bank_in      in   2   fault bank address
//  test_end     in   1   BIST finished
//  bist_en      out  1   BIST run enable
//  bist_pause   out  1   BIST must hold (FIFO near full)
//  flt_valid    out  1   fault record to analyzer valid
//  flt_data     out  30  {bank,row,col,col_flag}
//  flt_ready    in   1   analyzer accepts record
//  pivot_new    in   1   analyzer found a new pivot fault (1-cycle pulse)
//  ana_start    out  1   1-cycle pulse: run must-repair/final analysis
//  ana_done     in   1   analysis complete (pulse); ana_repair valid same cycle
//  ana_repair   in   1   repairable
//  sol_in_valid/sol_in[15:0]/sol_in_last  in   analyzer solution stream
//  sol_in_ready out  1   = !sol_valid | sol_ready
//  sol_valid    out  1   solution word valid (registered)
//  solution     out  16  {type[2:0],rc,bank[1:0],addr[9:0]}
//  sol_ready    in   1   downstream accepts word
//  early_term   out  1   pivot count exceeded total spares (sticky to next start)
//  repair       out  1   repair possible (valid when done=1)
//  done         out  1   session finished (level, cleared by start)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, counters 0.
//  TOTAL = spare_total(spare_struct): 00->4, 01->5, 10->6, 11->8.
//  IDLE:    start -> latch struct, clear counters/flags/done, bist_en=1 -> COLLECT.
//  COLLECT: fault_detect pushes record same cycle; pop on flt_valid&flt_ready; push+pop same cycle ok.
//           flt_valid = !empty (FWFT). bist_pause = (count >= FIFO_DEPTH-1).
//           fault_detect while full (pop not occurring) -> overflow: ABORT.
//           test_end -> bist_en=0 -> DRAIN (coincident fault_detect pushed first).
//  DRAIN:   FIFO empty and no handshake in flight -> ana_start pulse -> ANALYZE.
//  pivot_new in COLLECT/DRAIN increments pivot_cnt (saturating); pivot_cnt > TOTAL -> early_term=1 -> ABORT.
//  ANALYZE: ana_done -> repair<=ana_repair; repair ? REPORT : DONE.
//  REPORT:  one-stage registered forward of sol_in; words counted; accepted word with sol_in_last,
//           or count reaching TOTAL -> DONE after final sol_ready handshake.
//  ABORT:   flush FIFO, bist_en=0, repair=0, flt_valid=0 -> DONE.
//  DONE:    done=1 held; start re-enters session (clears early_term, repair, done).
//  start outside IDLE/DONE ignored. ana_done outside ANALYZE ignored. pivot_new outside COLLECT/DRAIN ignored.
//  Async reset mid-session returns to reset state immediately; no partial outputs persist.
// CONFIGURATION
//  BIRA_FAULT_DEDUP_EN defined: fault_detect whose {bank,row,col,col_flag} equals last pushed
//   record is dropped (no push, no overflow check). Last-record register cleared at start.
//  Undefined: every fault_detect pushes.
// STRUCTURE
//  bira_pkg: FSM state encoding, FLT_W=30, SOL_W=16, spare_total() function/table.
//  Sub-module bira_fault_fifo (sync FWFT FIFO, push/pop/flush, count, full/empty).
// TESTING
//  struct=00, 3 faults, test_end, ana_done repair=1, 2 sol words (last on 2nd) -> 2 words out, done=1, repair=1.
//  flt_ready=0, 8 faults back-to-back -> bist_pause at count 7; 9th fault -> ABORT, done=1, repair=0.
//  struct=00, 5 pivot_new pulses -> early_term=1 after 5th, bist_en=0, FIFO flushed, done=1.
//  test_end + fault_detect same cycle -> fault delivered before ana_start; ana_start exactly 1 cycle.
//  sol_ready low 3 cycles in REPORT -> solution/sol_valid stable, sol_in_ready=0, no word lost.
//  DEDUP_EN: identical fault twice -> 1 record; without macro -> 2 records.

Source files
------------

// File: rtl/bira_pkg.sv
// Shared definitions for the BIRA session sequencer: FSM encoding, record widths
// and the spare-structure to total-spare-count table.
package bira_pkg;

    localparam int FLT_W = 30;
    localparam int SOL_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_ANALYZE = 3'd3;
    localparam logic [2:0] ST_REPORT  = 3'd4;
    localparam logic [2:0] ST_ABORT   = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    function automatic logic [3:0] spare_total(input logic [1:0] spare_struct);
        logic [3:0] total;
        total = 4'd4;
        case (spare_struct)
            2'b00:   total = 4'd4;
            2'b01:   total = 4'd5;
            2'b10:   total = 4'd6;
            default: total = 4'd8;
        endcase
        return total;
    endfunction

endpackage

// File: rtl/bira_fault_fifo.sv
// Synchronous first-word-fall-through FIFO for fault records; zero-latency head, push into a full
// FIFO is accepted only alongside a pop, pop from empty is ignored, flush empties it in one cycle.
module bira_fault_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/bira_seq_ctrl.sv
// BIRA session sequencer: BIST fault FIFO, analyzer handshake, one-stage solution forwarding.
// Optional BIRA_FAULT_DEDUP_EN drops a fault identical to the last pushed record.
module bira_seq_ctrl
    import bira_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       spare_struct,
    input  logic             fault_detect,
    input  logic [9:0]       row_add_in,
    input  logic [9:0]       col_add_in,
    input  logic [7:0]       col_flag,
    input  logic [1:0]       bank_in,
    input  logic             test_end,
    output logic             bist_en,
    output logic             bist_pause,
    output logic             flt_valid,
    output logic [FLT_W-1:0] flt_data,
    input  logic             flt_ready,
    input  logic             pivot_new,
    output logic             ana_start,
    input  logic             ana_done,
    input  logic             ana_repair,
    input  logic             sol_in_valid,
    input  logic [SOL_W-1:0] sol_in,
    input  logic             sol_in_last,
    output logic             sol_in_ready,
    output logic             sol_valid,
    output logic [SOL_W-1:0] solution,
    input  logic             sol_ready,
    output logic             early_term,
    output logic             repair,
    output logic             done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]       state_q, state_d;
    logic [1:0]       struct_q, struct_d;
    logic [CNT_W-1:0] pivot_cnt_q, pivot_cnt_d;
    logic [CNT_W-1:0] sol_cnt_q, sol_cnt_d;
    logic             bist_en_q, bist_en_d;
    logic             ana_start_q, ana_start_d;
    logic             sol_valid_q, sol_valid_d;
    logic             sol_fin_q, sol_fin_d;
    logic [SOL_W-1:0] solution_q, solution_d;
    logic             early_term_q, early_term_d;
    logic             repair_q, repair_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] total, pivot_nxt, sol_cnt_inc;
    logic [FLT_W-1:0] rec, fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             in_run, start_ok, dup, fault_req, overflow, push, pop, flush;
    logic             pivot_trip, sol_load, sol_take, load_final;

    assign total       = CNT_W'(spare_total(struct_q));
    assign rec         = {bank_in, row_add_in, col_add_in, col_flag};
    assign in_run      = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    assign flt_valid   = in_run && !fifo_empty;
    assign flt_data    = flt_valid ? fifo_dout : '0;
    assign pop         = flt_valid && flt_ready;
    assign fault_req   = (state_q == ST_COLLECT) && fault_detect && !dup;
    // A full FIFO can still take a record in the same cycle its head leaves.
    assign overflow    = fault_req && fifo_full && !pop;
    assign push        = fault_req && !overflow;
    assign flush       = start_ok || (state_q == ST_ABORT);

    assign pivot_nxt   = (&pivot_cnt_q) ? pivot_cnt_q : pivot_cnt_q + CNT_W'(1);
    assign pivot_trip  = in_run && pivot_new && (pivot_nxt > total);

    assign sol_in_ready = (state_q == ST_REPORT) && !sol_fin_q && (!sol_valid_q || sol_ready);
    assign sol_load     = sol_in_valid && sol_in_ready;
    assign sol_take     = sol_valid_q && sol_ready;
    assign sol_cnt_inc  = sol_cnt_q + CNT_W'(1);
    assign load_final   = sol_in_last || (sol_cnt_inc >= total);

    assign bist_en    = bist_en_q;
    assign bist_pause = (state_q == ST_COLLECT) && (fifo_count >= CW'(FIFO_DEPTH - 1));
    assign ana_start  = ana_start_q;
    assign sol_valid  = sol_valid_q;
    assign solution   = solution_q;
    assign early_term = early_term_q;
    assign repair     = repair_q;
    assign done       = done_q;

`ifdef BIRA_FAULT_DEDUP_EN
    logic [FLT_W-1:0] last_q, last_d;
    logic             last_vld_q, last_vld_d;

    assign dup = last_vld_q && (rec == last_q);

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (start_ok) begin
            last_d     = '0;
            last_vld_d = 1'b0;
        end else if (push) begin
            last_d     = rec;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    bira_fault_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FLT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (rec),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        struct_d     = struct_q;
        pivot_cnt_d  = pivot_cnt_q;
        sol_cnt_d    = sol_cnt_q;
        bist_en_d    = bist_en_q;
        ana_start_d  = 1'b0;
        sol_valid_d  = sol_valid_q;
        sol_fin_d    = sol_fin_q;
        solution_d   = solution_q;
        early_term_d = early_term_q;
        repair_d     = repair_q;
        done_d       = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    struct_d     = spare_struct;
                    pivot_cnt_d  = '0;
                    sol_cnt_d    = '0;
                    sol_valid_d  = 1'b0;
                    sol_fin_d    = 1'b0;
                    solution_d   = '0;
                    early_term_d = 1'b0;
                    repair_d     = 1'b0;
                    done_d       = 1'b0;
                    bist_en_d    = 1'b1;
                    state_d      = ST_COLLECT;
                end
            end
            ST_COLLECT, ST_DRAIN: begin
                if (pivot_new) pivot_cnt_d = pivot_nxt;
                if (pivot_trip) begin
                    early_term_d = 1'b1;
                    bist_en_d    = 1'b0;
                    state_d      = ST_ABORT;
                end else if (state_q == ST_COLLECT) begin
                    if (overflow) begin
                        bist_en_d = 1'b0;
                        state_d   = ST_ABORT;
                    end else if (test_end) begin
                        bist_en_d = 1'b0;
                        state_d   = ST_DRAIN;
                    end
                end else if (fifo_empty) begin
                    ana_start_d = 1'b1;
                    state_d     = ST_ANALYZE;
                end
            end
            ST_ANALYZE: begin
                if (ana_done) begin
                    repair_d = ana_repair;
                    if (ana_repair) begin
                        state_d = ST_REPORT;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_REPORT: begin
                if (sol_load) begin
                    solution_d  = sol_in;
                    sol_valid_d = 1'b1;
                    sol_cnt_d   = sol_cnt_inc;
                    if (load_final) sol_fin_d = 1'b1;
                end else if (sol_take) begin
                    sol_valid_d = 1'b0;
                    if (sol_fin_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                bist_en_d = 1'b0;
                repair_d  = 1'b0;
                done_d    = 1'b1;
                state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            struct_q     <= '0;
            pivot_cnt_q  <= '0;
            sol_cnt_q    <= '0;
            bist_en_q    <= 1'b0;
            ana_start_q  <= 1'b0;
            sol_valid_q  <= 1'b0;
            sol_fin_q    <= 1'b0;
            solution_q   <= '0;
            early_term_q <= 1'b0;
            repair_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            struct_q     <= struct_d;
            pivot_cnt_q  <= pivot_cnt_d;
            sol_cnt_q    <= sol_cnt_d;
            bist_en_q    <= bist_en_d;
            ana_start_q  <= ana_start_d;
            sol_valid_q  <= sol_valid_d;
            sol_fin_q    <= sol_fin_d;
            solution_q   <= solution_d;
            early_term_q <= early_term_d;
            repair_q     <= repair_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_bira_seq_ctrl.sv
// Directed and randomized sessions for bira_seq_ctrl, scored against a queue-based session model.
module tb_bira_seq_ctrl;
    localparam int DEPTH = 8;
`ifdef BIRA_FAULT_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 0, fault_detect = 0, test_end = 0, flt_ready = 0, pivot_new = 0;
    logic        ana_done = 0, ana_repair = 0, sol_in_valid = 0, sol_in_last = 0, sol_ready = 0;
    logic [1:0]  spare_struct = 0, bank_in = 0;
    logic [9:0]  row_add_in = 0, col_add_in = 0;
    logic [7:0]  col_flag = 0;
    logic [15:0] sol_in = 0;
    logic        bist_en, bist_pause, flt_valid, ana_start, sol_in_ready, sol_valid;
    logic        early_term, repair, done;
    logic [29:0] flt_data;
    logic [15:0] solution;

    int checks = 0, errors = 0;
    int TOT [4] = '{4, 5, 6, 8};

    // session model
    logic [29:0] fq [$];
    logic [15:0] sq [$];
    bit          collecting = 0, running = 0, analyzing = 0, reporting = 0, fin = 0, last_vld = 0;
    bit          acc_evt = 0;
    logic [29:0] last_rec = 0;
    int          total_m = 4, piv = 0, nacc = 0;
    int          delivered = 0, words_out = 0, ana_pulses = 0;

    always #5 clk = ~clk;

    bira_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .spare_struct(spare_struct),
        .fault_detect(fault_detect), .row_add_in(row_add_in), .col_add_in(col_add_in),
        .col_flag(col_flag), .bank_in(bank_in), .test_end(test_end),
        .bist_en(bist_en), .bist_pause(bist_pause), .flt_valid(flt_valid), .flt_data(flt_data),
        .flt_ready(flt_ready), .pivot_new(pivot_new), .ana_start(ana_start), .ana_done(ana_done),
        .ana_repair(ana_repair), .sol_in_valid(sol_in_valid), .sol_in(sol_in),
        .sol_in_last(sol_in_last), .sol_in_ready(sol_in_ready), .sol_valid(sol_valid),
        .solution(solution), .sol_ready(sol_ready), .early_term(early_term),
        .repair(repair), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {bist_en, bist_pause, flt_valid, flt_data, ana_start, sol_in_ready,
                    sol_valid, solution, early_term, repair, done}, 64'd0);
    endtask

    task automatic model_reset();
        collecting = 0; running = 0; analyzing = 0; reporting = 0; fin = 0; last_vld = 0;
        fq.delete(); sq.delete();
    endtask

    // One clock: check outputs mid-cycle, advance the model, then step past the edge.
    task automatic tick();
        logic [29:0] rec, hd;
        logic [15:0] hs;
        bit dup;
        acc_evt = 0;
        @(negedge clk);
        check("flt_valid", flt_valid, fq.size() != 0);
        check("bist_pause", bist_pause, collecting && fq.size() >= DEPTH - 1);
        check("sol_valid", sol_valid, sq.size() != 0);
        check("sol_in_ready", sol_in_ready, reporting && !fin && (sq.size() == 0 || sol_ready));
        if (ana_start) begin
            ana_pulses++;
            check("ana_after_drain", fq.size(), 0);
            running = 0;
            analyzing = 1;
        end
        if (flt_valid && flt_ready && fq.size() != 0) begin
            hd = fq.pop_front();
            check("flt_data", flt_data, hd);
            delivered++;
        end
        if (fault_detect && collecting) begin
            rec = {bank_in, row_add_in, col_add_in, col_flag};
            dup = DEDUP && last_vld && (rec == last_rec);
            if (!dup) begin
                if (fq.size() == DEPTH) begin
                    collecting = 0; running = 0; fq.delete();
                end else begin
                    fq.push_back(rec); last_rec = rec; last_vld = 1;
                end
            end
        end
        if (test_end && collecting) collecting = 0;
        if (pivot_new && running) begin
            piv++;
            if (piv > total_m) begin
                collecting = 0; running = 0; fq.delete();
            end
        end
        if (ana_done && analyzing) begin
            analyzing = 0;
            if (ana_repair) reporting = 1;
        end
        if (sol_valid && sol_ready && sq.size() != 0) begin
            hs = sq.pop_front();
            check("solution", solution, hs);
            words_out++;
            if (fin && sq.size() == 0) reporting = 0;
        end
        if (sol_in_valid && sol_in_ready) begin
            acc_evt = 1;
            sq.push_back(sol_in);
            nacc++;
            if (sol_in_last || nacc >= total_m) fin = 1;
        end
        @(posedge clk);
        #1;
        start = 0; fault_detect = 0; test_end = 0; pivot_new = 0; ana_done = 0;
    endtask

    task automatic do_start(input logic [1:0] s);
        spare_struct = s;
        start = 1;
        model_reset();
        total_m = TOT[s]; collecting = 1; running = 1; piv = 0; nacc = 0;
        tick();
        check("start_bist_en", bist_en, 1);
        check("start_clears", {done, repair, early_term}, 0);
    endtask

    task automatic drive_fault(input logic [29:0] r);
        {bank_in, row_add_in, col_add_in, col_flag} = r;
        fault_detect = 1;
        tick();
    endtask

    task automatic wait_ana();
        int p0, n;
        p0 = ana_pulses; n = 0;
        while (ana_pulses == p0 && n < 100) begin
            flt_ready = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end
        check("ana_start_seen", ana_pulses - p0, 1);
    endtask

    task automatic send_sol(input logic [15:0] d, input logic last, input bit rnd);
        int n;
        n = 0;
        sol_in_valid = 1; sol_in = d; sol_in_last = last;
        do begin
            if (rnd) sol_ready = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end while (!acc_evt && n < 100);
        check("sol_accept", acc_evt, 1);
        sol_in_valid = 0; sol_in_last = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            sol_ready = 1;
            tick();
            n++;
        end
        check("done", done, 1);
    endtask

    initial begin
        int d0, w0, p0, nf, np, k;
        logic [1:0]  st;
        logic [29:0] r;
        logic [15:0] wa;
        logic        rp;

        #12;
        check_zero("reset_outputs");
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // basic repair session: 3 faults, 2 solution words
        d0 = delivered; w0 = words_out;
        do_start(2'b00);
        flt_ready = 1;
        for (int i = 0; i < 3; i++) drive_fault(30'($urandom));
        test_end = 1; tick();
        check("bist_en_off", bist_en, 0);
        wait_ana();
        ana_done = 1; ana_repair = 1; tick();
        send_sol(16'($urandom), 1'b0, 1'b1);
        send_sol(16'($urandom), 1'b1, 1'b1);
        wait_done();
        check("t1_repair", repair, 1);
        check("t1_faults", delivered - d0, 3);
        check("t1_words", words_out - w0, 2);

        // overflow: analyzer stalled, 9th fault aborts
        do_start(2'b01);
        flt_ready = 0;
        for (int i = 0; i < 8; i++) begin
            drive_fault(30'($urandom));
            if (i == 5) check("pause_at6", bist_pause, 0);
            if (i == 6) check("pause_at7", bist_pause, 1);
        end
        drive_fault(30'($urandom));
        check("ovf_bist_en", bist_en, 0);
        tick();
        check("ovf_done", done, 1);
        check("ovf_repair", repair, 0);
        check("ovf_early", early_term, 0);

        // early termination: 5 pivots with 4 spares
        do_start(2'b00);
        flt_ready = 0;
        drive_fault(30'($urandom));
        drive_fault(30'($urandom));
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("early_before", early_term, 0);
            pivot_new = 1; tick();
        end
        check("early_set", early_term, 1);
        check("early_bist_en", bist_en, 0);
        tick();
        check("early_done", done, 1);
        check("early_flushed", flt_valid, 0);

        // test_end coincident with a fault
        d0 = delivered; p0 = ana_pulses;
        do_start(2'b11);
        flt_ready = 0;
        drive_fault(30'($urandom));
        drive_fault(30'($urandom));
        test_end = 1; drive_fault(30'($urandom));
        wait_ana();
        check("coinc_faults", delivered - d0, 3);
        ana_done = 1; ana_repair = 0; tick();
        check("coinc_done", done, 1);
        tick();
        check("ana_start_one_cycle", ana_pulses - p0, 1);

        // output stall for 3 cycles in REPORT
        w0 = words_out;
        do_start(2'b01);
        test_end = 1; tick();
        wait_ana();
        ana_done = 1; ana_repair = 1; tick();
        sol_ready = 0;
        wa = 16'($urandom);
        send_sol(wa, 1'b0, 1'b0);
        sol_in_valid = 1; sol_in = 16'($urandom); sol_in_last = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_word", solution, wa);
            check("stall_ready", sol_in_ready, 0);
        end
        sol_ready = 1;
        send_sol(sol_in, 1'b1, 1'b0);
        wait_done();
        check("stall_words", words_out - w0, 2);

        // identical fault twice
        d0 = delivered;
        do_start(2'b00);
        flt_ready = 0;
        r = 30'($urandom);
        drive_fault(r);
        drive_fault(r);
        test_end = 1; tick();
        wait_ana();
        check("dedup_records", delivered - d0, DEDUP ? 1 : 2);
        ana_done = 1; ana_repair = 0; tick();

        // randomized sessions
        for (int s = 0; s < 6; s++) begin
            st = 2'($urandom_range(0, 3));
            d0 = delivered; w0 = words_out; p0 = ana_pulses;
            do_start(st);
            nf = $urandom_range(0, 6);
            for (int i = 0; i < nf; i++) begin
                flt_ready = ($urandom_range(0, 2) != 0);
                drive_fault(30'($urandom));
            end
            np = $urandom_range(0, total_m);
            for (int i = 0; i < np; i++) begin
                pivot_new = 1; tick();
            end
            test_end = 1;
            if ($urandom_range(0, 1) == 1) begin
                drive_fault(30'($urandom)); nf++;
            end else begin
                tick();
            end
            wait_ana();
            check("rnd_faults", delivered - d0, nf);
            rp = 1'($urandom_range(0, 1));
            k = 0;
            ana_done = 1; ana_repair = rp; tick();
            if (rp) begin
                k = $urandom_range(1, total_m);
                for (int i = 1; i <= k; i++)
                    send_sol(16'($urandom), (i == k) && (k < total_m || $urandom_range(0, 1) == 1), 1'b1);
            end
            wait_done();
            check("rnd_repair", repair, rp);
            check("rnd_words", words_out - w0, k);
            check("rnd_ana_pulses", ana_pulses - p0, 1);
            check("rnd_early", early_term, 0);
        end

        // asynchronous reset in the middle of a session
        do_start(2'b10);
        flt_ready = 0;
        for (int i = 0; i < 3; i++) drive_fault(30'($urandom));
        #2 rst = 1;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        tick();
        check_zero("after_reset");
        do_start(2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
